// File: rtl/oam_dma_master.sv
// ----------------------------------------------------------------------------
// oam_dma_master
//
// Purpose:
//   Snoops CPU writes to FF46. Each new write starts a 160-byte copy from
//   {value, 8'h00} into OAM at FE00..FE9F. Source pages E0..FF alias to
//   C0..DF (echo RAM), so bit 5 of the page is cleared for those values.
//   Every byte takes one READ access and one WRITE access, and either access
//   can be stretched by the responder with dma_wait_n.
//
// Ports:
//   clk, Reset              system clock, synchronous active-high reset
//   cpu_write_n/address/dout  snooped CPU write bus
//   dma_mreq_n/read_n/write_n active-low DMA strobes (registered)
//   dma_address, dma_dout     DMA bus address and write data (registered)
//   dma_din, dma_wait_n       read data and ready from the memory unit
//   bus_request               high while DMA owns the bus (external mux select)
//   busy                      high from START until the last OAM write completes
//   dma_reg                   readback of the last value written to FF46
// ----------------------------------------------------------------------------
module oam_dma_master (
    input  logic        clk,
    input  logic        Reset,
    input  logic        cpu_write_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_dout,
    output logic        dma_mreq_n,
    output logic        dma_read_n,
    output logic        dma_write_n,
    output logic [15:0] dma_address,
    output logic [7:0]  dma_dout,
    input  logic [7:0]  dma_din,
    input  logic        dma_wait_n,
    output logic        bus_request,
    output logic        busy,
    output logic [7:0]  dma_reg
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LastIdx = 8'd159;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    logic        qual_q;

    logic        mreq_n_q, mreq_n_d;
    logic        read_n_q, read_n_d;
    logic        write_n_q, write_n_d;
    logic [15:0] address_q, address_d;
    logic [7:0]  dout_q, dout_d;
    logic        bus_req_q, bus_req_d;
    logic        busy_q, busy_d;

    logic        qual;
    logic        start;

    // A start is the rising edge of the FF46 write qualifier, so a CPU write
    // held over several cycles launches only one transfer.
    assign qual  = !cpu_write_n && (cpu_address == 16'hFF46);
    assign start = qual && !qual_q;

    // Next-state logic. A start overrides whatever the sequencer was doing,
    // which both aborts an in-flight byte and wins over the final WRITE
    // completion. Outputs are derived from the next state so they can be
    // registered and stay glitch-free for the whole access.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        src_hi_d  = src_hi_q;
        dma_reg_d = dma_reg_q;

        case (state_q)
            IDLE:  state_d = IDLE;
            START: state_d = READ;
            READ: begin
                if (dma_wait_n) begin
                    data_d  = dma_din;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (dma_wait_n) begin
                    if (idx_q == LastIdx) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            dma_reg_d = cpu_dout;
            src_hi_d  = (cpu_dout >= 8'hE0) ? (cpu_dout & 8'hDF) : cpu_dout;
            idx_d     = 8'd0;
            state_d   = START;
        end

        mreq_n_d  = !((state_d == READ) || (state_d == WRITE));
        read_n_d  = (state_d != READ);
        write_n_d = (state_d != WRITE);
        bus_req_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
        address_d = address_q;
        dout_d    = dout_q;
        if (state_d == READ) begin
            address_d = {src_hi_d, idx_d};
        end else if (state_d == WRITE) begin
            address_d = {8'hFE, idx_d};
            dout_d    = data_d;
        end
    end

    // State and output registers; Reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            data_q    <= 8'd0;
            src_hi_q  <= 8'd0;
            dma_reg_q <= 8'h00;
            qual_q    <= 1'b0;
            mreq_n_q  <= 1'b1;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            address_q <= 16'd0;
            dout_q    <= 8'd0;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            src_hi_q  <= src_hi_d;
            dma_reg_q <= dma_reg_d;
            qual_q    <= qual;
            mreq_n_q  <= mreq_n_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            address_q <= address_d;
            dout_q    <= dout_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
        end
    end

    assign dma_mreq_n  = mreq_n_q;
    assign dma_read_n  = read_n_q;
    assign dma_write_n = write_n_q;
    assign dma_address = address_q;
    assign dma_dout    = dout_q;
    assign bus_request = bus_req_q;
    assign busy        = busy_q;
    assign dma_reg     = dma_reg_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// ----------------------------------------------------------------------------
// tb_oam_dma_master
//
// Self-checking bench for oam_dma_master. Each FF46 write loads the expected
// source-read addresses and OAM writes into queues; a monitor pops and
// compares them as the DUT completes accesses. Directed sequences cover the
// plain copy, echo mapping, wait stretching, held/aborting writes, reset and
// a start landing on the final write.
// ----------------------------------------------------------------------------
module tb_oam_dma_master;

    logic        clk;
    logic        reset;
    logic        cpuWriteN;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDout;
    logic        dmaMreqN;
    logic        dmaReadN;
    logic        dmaWriteN;
    logic [15:0] dmaAddress;
    logic [7:0]  dmaDout;
    logic [7:0]  dmaDin;
    logic        waitN;
    logic        busRequest;
    logic        busy;
    logic [7:0]  dmaReg;

    int assertCount = 0;
    int failCount   = 0;
    int busyCount   = 0;

    logic [15:0] rdQ[$];
    logic [15:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    logic [7:0]  feMem[160];

    oam_dma_master dut (
        .clk         (clk),
        .Reset       (reset),
        .cpu_write_n (cpuWriteN),
        .cpu_address (cpuAddress),
        .cpu_dout    (cpuDout),
        .dma_mreq_n  (dmaMreqN),
        .dma_read_n  (dmaReadN),
        .dma_write_n (dmaWriteN),
        .dma_address (dmaAddress),
        .dma_dout    (dmaDout),
        .dma_din     (dmaDin),
        .dma_wait_n  (waitN),
        .bus_request (busRequest),
        .busy        (busy),
        .dma_reg     (dmaReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory content: page C1 holds its own offset, other pages are
    // offset-XOR-page-delta so a wrong page shows up as wrong data.
    function automatic logic [7:0] srcData(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] - 8'hC1);
    endfunction

    // While the responder stalls, the read bus carries junk so an early
    // capture is visible in the written data.
    assign dmaDin = waitN ? srcData(dmaAddress) : 8'hEE;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic flushExpected();
        rdQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        busyCount = 0;
    endtask

    // Expected traffic for a transfer started by writing val to FF46.
    task automatic loadExpected(input logic [7:0] val);
        logic [7:0] page;
        flushExpected();
        page = (val >= 8'hE0) ? (val & 8'hDF) : val;
        for (int i = 0; i < 160; i++) begin
            rdQ.push_back({page, i[7:0]});
            wrAddrQ.push_back(16'hFE00 + 16'(i));
            wrDataQ.push_back(srcData({page, i[7:0]}));
        end
    endtask

    // Called just after a rising edge; holds the FF46 write for hold edges.
    task automatic applyStimulus(input logic [7:0] val, input int hold);
        cpuWriteN  = 1'b0;
        cpuAddress = 16'hFF46;
        cpuDout    = val;
        @(posedge clk); #1;
        loadExpected(val);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
        end
        cpuWriteN  = 1'b1;
        cpuAddress = 16'h0000;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    task automatic advance(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: an access completes at the next edge when its
    // strobe is low and the responder is ready.
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [7:0]  ed;
        if (busy) busyCount++;
        if (!dmaReadN && !dmaWriteN) checkOutput("bothStrobes", 32'd1, 32'd0);
        if (!dmaMreqN && !dmaReadN && waitN) begin
            if (rdQ.size() == 0) begin
                checkOutput("unexpectedRead", 32'(dmaAddress), 32'hFFFFFFFF);
            end else begin
                ea = rdQ.pop_front();
                checkOutput("readAddr", 32'(dmaAddress), 32'(ea));
            end
        end
        if (!dmaMreqN && !dmaWriteN && waitN) begin
            if (wrAddrQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(dmaAddress), 32'hFFFFFFFF);
            end else begin
                ea = wrAddrQ.pop_front();
                ed = wrDataQ.pop_front();
                checkOutput("writeAddr", 32'(dmaAddress), 32'(ea));
                checkOutput("writeData", 32'(dmaDout), 32'(ed));
                if (dmaAddress >= 16'hFE00 && dmaAddress <= 16'hFE9F)
                    feMem[dmaAddress[7:0]] = dmaDout;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        cpuWriteN  = 1'b1;
        cpuAddress = 16'h0000;
        cpuDout    = 8'h00;
        waitN      = 1'b1;
        for (int i = 0; i < 160; i++) feMem[i] = 8'h00;

        // Reset state
        advance(3);
        checkOutput("rstStrobes", 32'({dmaMreqN, dmaReadN, dmaWriteN}), 32'h7);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstBusReq", 32'(busRequest), 32'd0);
        checkOutput("rstReg", 32'(dmaReg), 32'h00);
        checkOutput("rstAddr", 32'(dmaAddress), 32'h0000);
        checkOutput("rstDout", 32'(dmaDout), 32'h00);
        reset = 1'b0;
        advance(1);

        // Plain copy from C100
        applyStimulus(8'hC1, 1);
        checkOutput("c1StartBusy", 32'(busy), 32'd1);
        checkOutput("c1StartBusReq", 32'(busRequest), 32'd1);
        checkOutput("c1StartStrobes", 32'({dmaMreqN, dmaReadN, dmaWriteN}), 32'h7);
        checkOutput("c1Reg", 32'(dmaReg), 32'hC1);
        waitIdle(1000);
        checkOutput("c1BusyCycles", 32'(busyCount), 32'd321);
        checkOutput("c1WrLeft", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("c1Fe00", 32'(feMem[0]), 32'd0);
        checkOutput("c1Fe9f", 32'(feMem[159]), 32'd159);
        checkOutput("c1IdleBusReq", 32'(busRequest), 32'd0);

        // Echo page E2 reads C2xx
        applyStimulus(8'hE2, 1);
        checkOutput("e2Reg", 32'(dmaReg), 32'hE2);
        waitIdle(1000);
        checkOutput("e2BusyCycles", 32'(busyCount), 32'd321);
        checkOutput("e2WrLeft", 32'(wrAddrQ.size()), 32'd0);

        // Three wait cycles during READ of idx 5 (cycle 11 after START)
        applyStimulus(8'hC1, 1);
        advance(11);
        waitN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("waitAddr", 32'(dmaAddress), 32'hC105);
            checkOutput("waitRead", 32'(dmaReadN), 32'd0);
            advance(1);
        end
        waitN = 1'b1;
        checkOutput("waitAddrHeld", 32'(dmaAddress), 32'hC105);
        waitIdle(1000);
        checkOutput("waitBusyCycles", 32'(busyCount), 32'd324);
        checkOutput("waitWrLeft", 32'(wrAddrQ.size()), 32'd0);

        // Held write starts once; rewrite C3 during READ of idx 50 aborts it
        applyStimulus(8'hC1, 10);
        advance(92);
        checkOutput("abortAt50", 32'(dmaAddress), 32'hC132);
        applyStimulus(8'hC3, 1);
        checkOutput("abortReg", 32'(dmaReg), 32'hC3);
        checkOutput("abortBusy", 32'(busy), 32'd1);
        checkOutput("abortStrobes", 32'({dmaMreqN, dmaReadN, dmaWriteN}), 32'h7);
        waitIdle(1000);
        checkOutput("abortBusyCycles", 32'(busyCount), 32'd321);
        checkOutput("abortWrLeft", 32'(wrAddrQ.size()), 32'd0);

        // Reset during WRITE of idx 80
        applyStimulus(8'hC1, 1);
        advance(162);
        checkOutput("rstMidWrite", 32'(dmaWriteN), 32'd0);
        checkOutput("rstMidAddr", 32'(dmaAddress), 32'hFE50);
        reset = 1'b1;
        advance(1);
        reset = 1'b0;
        flushExpected();
        checkOutput("rstMidStrobes", 32'({dmaMreqN, dmaReadN, dmaWriteN}), 32'h7);
        checkOutput("rstMidBusy", 32'(busy), 32'd0);
        checkOutput("rstMidBusReq", 32'(busRequest), 32'd0);
        checkOutput("rstMidReg", 32'(dmaReg), 32'h00);
        advance(5);
        checkOutput("rstStayIdle", 32'(busy), 32'd0);

        // Reset coincident with a start
        reset      = 1'b1;
        cpuWriteN  = 1'b0;
        cpuAddress = 16'hFF46;
        cpuDout    = 8'hC1;
        advance(1);
        reset     = 1'b0;
        cpuWriteN = 1'b1;
        checkOutput("rstVsStartBusy", 32'(busy), 32'd0);
        checkOutput("rstVsStartReg", 32'(dmaReg), 32'h00);
        advance(2);
        checkOutput("rstVsStartIdle", 32'(busy), 32'd0);

        // Start landing on the completion edge of idx 159
        applyStimulus(8'h40, 1);
        advance(320);
        checkOutput("lastWrite", 32'(dmaWriteN), 32'd0);
        checkOutput("lastAddr", 32'(dmaAddress), 32'hFE9F);
        applyStimulus(8'hE5, 1);
        checkOutput("chainBusy", 32'(busy), 32'd1);
        checkOutput("chainBusReq", 32'(busRequest), 32'd1);
        checkOutput("chainStrobes", 32'({dmaMreqN, dmaReadN, dmaWriteN}), 32'h7);
        checkOutput("chainReg", 32'(dmaReg), 32'hE5);
        waitIdle(1000);
        checkOutput("chainBusyCycles", 32'(busyCount), 32'd321);
        checkOutput("chainWrLeft", 32'(wrAddrQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/oam_dma_master.md
OAM_DMA_MASTER -- requirements
Module: oam_dma_master

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 cpu_write_n  input  1  CPU write strobe (active low), snooped.
REQ-004 cpu_address  input  16  CPU bus address, snooped.
REQ-005 cpu_dout  input  8  CPU write data, snooped.
REQ-006 dma_mreq_n  output  1  DMA memory request (active low).
REQ-007 dma_read_n  output  1  DMA read strobe (active low).
REQ-008 dma_write_n  output  1  DMA write strobe (active low).
REQ-009 dma_address  output  16  DMA bus address.
REQ-010 dma_dout  output  8  DMA write data.
REQ-011 dma_din  input  8  read data returned by the memory unit.
REQ-012 dma_wait_n  input  1  responder ready; low stretches the current access.
REQ-013 bus_request  output  1  high while DMA owns the memory bus (external mux select).
REQ-014 busy  output  1  high from transfer start until the last byte is written.
REQ-015 dma_reg  output  8  last value written to FF46 (readback).

Function
REQ-016 Trigger: qualifier = (cpu_write_n==0 && cpu_address==16'hFF46); a start fires on the first cycle the qualifier is true after a cycle where it was false; a held write does not retrigger.
REQ-017 On start: dma_reg <= cpu_dout; src_hi <= cpu_dout, with bit 5 cleared when cpu_dout >= 8'hE0 (echo mapping); idx <= 0; state <= START.
REQ-018 States: IDLE, START, READ, WRITE; all outputs are registered.
REQ-019 IDLE: bus_request=0, busy=0, dma_mreq_n=dma_read_n=dma_write_n=1.
REQ-020 START: one cycle of bus handover; bus_request=1, busy=1, strobes inactive; next state READ.
REQ-021 READ: dma_mreq_n=0, dma_read_n=0, dma_address={src_hi, idx}; on an edge with dma_wait_n=1, latch dma_din into data_q and go to WRITE; otherwise hold.
REQ-022 WRITE: dma_mreq_n=0, dma_write_n=0, dma_address=16'hFE00+idx, dma_dout=data_q; on an edge with dma_wait_n=1: if idx==159 go to IDLE, else idx<=idx+1 and go to READ; otherwise hold.
REQ-023 idx is 8 bits, range 0..159; it never exceeds 159 and never wraps.
REQ-024 Zero-wait transfer: 1 START cycle + 320 access cycles; busy is high for exactly 321 cycles; each wait-low cycle adds one cycle.
REQ-025 dma_read_n and dma_write_n are never low in the same cycle; strobes change only on state transitions.
REQ-026 A start while busy aborts the current byte immediately, with no write of the pending data_q, and restarts at START with the new source and idx=0.
REQ-027 A start coincident with the final WRITE completion takes precedence: the next state is START, not IDLE.
REQ-028 bus_request and busy fall on the same edge that completes the write of idx 159.

Reset
REQ-029 Reset high at an edge forces: state IDLE, idx 0, data_q 0, src_hi 0, dma_reg 8'h00, dma_address 0, dma_dout 0, all strobes 1, bus_request 0, busy 0, qualifier history 0.
REQ-030 Reset mid-transfer aborts with no further strobes; Reset takes precedence over a simultaneous start.

Verification
REQ-031 Write 8'hC1 to FF46, dma_wait_n=1, memory C100+i=i -> FE00..FE9F hold 0..159; busy high for 321 cycles; dma_reg=8'hC1.
REQ-032 Write 8'hE2 -> source reads hit C200..C29F; dma_reg=8'hE2.
REQ-033 dma_wait_n low for 3 cycles during READ of idx 5 -> address held at src+5, dma_din captured only after wait_n rises; total busy cycles 324.
REQ-034 Hold FF46 write for 10 cycles -> exactly one start occurs; a second write of 8'hC3 at idx 50 -> restarts at C300, idx 0, and FE32 receives no stale write.
REQ-035 Reset asserted in WRITE of idx 80 -> next cycle all strobes 1, busy 0, bus_request 0, dma_reg 8'h00.
REQ-036 FF46 write on the completion edge of idx 159 -> state START, busy stays high continuously.
